// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: segment decode and
// output polarity helpers.
package seg7_pkg;

  localparam int POL_ACTIVE_HIGH = 0;
  localparam int POL_ACTIVE_LOW  = 1;

  // Segment byte with every segment and the decimal point dark, active-high.
  localparam logic [7:0] SEG_DARK_HIGH = 8'h00;

  // Hex nibble to active-high segment pattern, bit order g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'h0:    pattern = 7'h3F;
      4'h1:    pattern = 7'h06;
      4'h2:    pattern = 7'h5B;
      4'h3:    pattern = 7'h4F;
      4'h4:    pattern = 7'h66;
      4'h5:    pattern = 7'h6D;
      4'h6:    pattern = 7'h7D;
      4'h7:    pattern = 7'h07;
      4'h8:    pattern = 7'h7F;
      4'h9:    pattern = 7'h6F;
      4'hA:    pattern = 7'h77;
      4'hB:    pattern = 7'h7C;
      4'hC:    pattern = 7'h39;
      4'hD:    pattern = 7'h5E;
      4'hE:    pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
    return pattern;
  endfunction

  // Converts an active-high segment byte to the polarity of the board wiring.
  function automatic logic [7:0] seg_polarity(input logic [7:0] pattern, input int polarity);
    return (polarity == POL_ACTIVE_LOW) ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Slot timing for the digit scan: slot counter, digit index and frame marker.
module seg7_tick_gen #(
  parameter int SLOT_TICKS = 10,
  parameter int NUM_DIGITS = 3,
  parameter int SLOT_W     = 4,
  parameter int DIG_W      = 2
) (
  input  logic              pix_clk,
  input  logic              pix_rstn,
  output logic [SLOT_W-1:0] slot_cnt,
  output logic [DIG_W-1:0]  dig_idx,
  output logic              frame_wrap,
  output logic              frame_tick
);

  logic slot_last;
  logic digit_last;

  // Detect the final cycle of a slot and of the last digit; together they end a frame.
  always_comb begin
    slot_last  = (slot_cnt == SLOT_W'(SLOT_TICKS - 1));
    digit_last = (dig_idx == DIG_W'(NUM_DIGITS - 1));
    frame_wrap = slot_last && digit_last;
  end

  // Advance the slot counter every cycle and step to the next digit when a slot ends.
  always_ff @(posedge pix_clk or negedge pix_rstn) begin
    if (!pix_rstn) begin
      slot_cnt   <= '0;
      dig_idx    <= '0;
      frame_tick <= 1'b0;
    end else begin
      slot_cnt   <= slot_last ? '0 : slot_cnt + 1'b1;
      frame_tick <= frame_wrap;
      if (slot_last) begin
        dig_idx <= digit_last ? '0 : dig_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: double-buffered hex display with leading
// zero blanking, PWM brightness and a dead band at the start of every slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ         = 108_000_000,
  parameter int NUM_DIGITS     = 3,
  parameter int DIGIT_HZ       = 1000,
  parameter int PWM_BITS       = 4,
  parameter int GUARD_TICKS    = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    pix_clk,
  input  logic                    pix_rstn,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame_tick
);

  localparam int SLOT_TICKS = CLK_HZ / DIGIT_HZ;
  localparam int SLOT_W     = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam int DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SEG_POL    = (SEG_ACTIVE_LOW != 0) ? POL_ACTIVE_LOW : POL_ACTIVE_HIGH;
  localparam logic [7:0] SEG_OFF = seg_polarity(SEG_DARK_HIGH, SEG_POL);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  // Reject parameter sets where a slot cannot hold the dead band plus a full PWM period.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $fatal(1, "seg7_scan_driver: NUM_DIGITS must be within 1..8");
  end
  if (SLOT_TICKS < GUARD_TICKS + 2**PWM_BITS) begin : g_bad_slot_ticks
    $fatal(1, "seg7_scan_driver: slot too short for guard band plus PWM period");
  end

  logic [SLOT_W-1:0]       slot_cnt;
  logic [DIG_W-1:0]        dig_idx;
  logic                    frame_wrap;
  logic [PWM_BITS-1:0]     pwm_cnt;
  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] disp_value;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    active;
  logic [7:0]              seg_high;
  logic [NUM_DIGITS-1:0]   dig_high;

  seg7_tick_gen #(
    .SLOT_TICKS (SLOT_TICKS),
    .NUM_DIGITS (NUM_DIGITS),
    .SLOT_W     (SLOT_W),
    .DIG_W      (DIG_W)
  ) u_tick_gen (
    .pix_clk    (pix_clk),
    .pix_rstn   (pix_rstn),
    .slot_cnt   (slot_cnt),
    .dig_idx    (dig_idx),
    .frame_wrap (frame_wrap),
    .frame_tick (frame_tick)
  );

  // Shadow takes new data on any load; the display copy only moves at a frame boundary so a frame never mixes old and new digits.
  always_ff @(posedge pix_clk or negedge pix_rstn) begin
    if (!pix_rstn) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      disp_value   <= '0;
      disp_dp      <= '0;
    end else begin
      if (frame_wrap) begin
        disp_value <= shadow_value;
        disp_dp    <= shadow_dp;
      end
      if (load) begin
        shadow_value <= value;
        shadow_dp    <= dp;
      end
    end
  end

  // Free-running PWM phase counter, independent of slot timing.
  always_ff @(posedge pix_clk or negedge pix_rstn) begin
    if (!pix_rstn) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Mark each digit whose nibble and every more significant nibble are zero.
  always_comb begin
    logic zero_run;
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run && (disp_value[4*k +: 4] == 4'h0);
      lead_zero[k] = zero_run;
    end
  end

  // Build the active-high pattern for the digit in its slot, dark during the guard band and PWM off phase.
  always_comb begin
    seg_high = SEG_DARK_HIGH;
    dig_high = '0;
    active   = (slot_cnt >= SLOT_W'(GUARD_TICKS)) && ((&brightness) || (pwm_cnt < brightness));
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_idx == DIG_W'(k)) begin
        dig_high[k] = 1'b1;
        if (blank_lz && (k > 0) && lead_zero[k]) begin
          seg_high = {disp_dp[k], 7'h00};
        end else begin
          seg_high = {disp_dp[k], hex_to_seg(disp_value[4*k +: 4])};
        end
      end
    end
    if (!active) begin
      seg_high = SEG_DARK_HIGH;
      dig_high = '0;
    end
  end

  // Register the pins in board polarity so they change glitch-free on the clock edge.
  always_ff @(posedge pix_clk or negedge pix_rstn) begin
    if (!pix_rstn) begin
      seg <= SEG_OFF;
      dig <= DIG_OFF;
    end else begin
      seg <= seg_polarity(seg_high, SEG_POL);
      dig <= (DIG_ACTIVE_LOW != 0) ? ~dig_high : dig_high;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with a 10-cycle slot, 3 digits,
// 2-bit PWM and a 1-cycle guard band, both outputs active-low.
module tb_seg7_scan_driver;

  typedef struct packed {
    logic [7:0] seg;
    logic [2:0] dig;
    logic       tick;
  } exp_t;

  logic        pix_clk;
  logic        pix_rstn;
  logic [11:0] value;
  logic [2:0]  dp;
  logic        load;
  logic        blank_lz;
  logic [1:0]  brightness;
  logic [7:0]  seg;
  logic [2:0]  dig;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  int          m_slot;
  int          m_idx;
  int          m_pwm;
  logic [11:0] m_shadow;
  logic [2:0]  m_sdp;
  logic [11:0] m_disp;
  logic [2:0]  m_ddp;

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [7:0] cap_seg [30];
  logic [2:0] cap_dig [30];
  logic       cap_tick [30];

  seg7_scan_driver #(
    .CLK_HZ         (1000),
    .NUM_DIGITS     (3),
    .DIGIT_HZ       (100),
    .PWM_BITS       (2),
    .GUARD_TICKS    (1),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .pix_clk    (pix_clk),
    .pix_rstn   (pix_rstn),
    .value      (value),
    .dp         (dp),
    .load       (load),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .seg        (seg),
    .dig        (dig),
    .frame_tick (frame_tick)
  );

  // 10-unit clock period.
  initial pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected pin values after the coming edge, from the model's pre-edge state.
  function automatic exp_t modelOutput();
    exp_t       e;
    logic       act;
    logic       blank;
    logic [3:0] nib;
    act = (m_slot >= 1) && ((brightness == 2'd3) || (m_pwm < int'(brightness)));
    if (act) begin
      nib   = m_disp[4*m_idx +: 4];
      blank = blank_lz && (m_idx > 0) && ((m_disp >> (4*m_idx)) == 12'h000);
      e.seg = ~{m_ddp[m_idx], (blank ? 7'h00 : seg_tbl[nib])};
      e.dig = ~(3'b001 << m_idx);
    end else begin
      e.seg = 8'hFF;
      e.dig = 3'b111;
    end
    e.tick = (m_slot == 9) && (m_idx == 2);
    return e;
  endfunction

  // Reference model: pushes the expected pins for each edge, then advances its own state.
  always @(posedge pix_clk or negedge pix_rstn) begin
    if (!pix_rstn) begin
      m_slot   <= 0;
      m_idx    <= 0;
      m_pwm    <= 0;
      m_shadow <= '0;
      m_sdp    <= '0;
      m_disp   <= '0;
      m_ddp    <= '0;
      exp_q.delete();
    end else begin
      exp_q.push_back(modelOutput());
      if ((m_slot == 9) && (m_idx == 2)) begin
        m_disp <= m_shadow;
        m_ddp  <= m_sdp;
      end
      if (load) begin
        m_shadow <= value;
        m_sdp    <= dp;
      end
      m_pwm <= (m_pwm + 1) % 4;
      if (m_slot == 9) begin
        m_slot <= 0;
        m_idx  <= (m_idx + 1) % 3;
      end else begin
        m_slot <= m_slot + 1;
      end
    end
  end

  // Scoreboard: compare DUT pins against the model half a cycle after each edge.
  always @(negedge pix_clk) begin
    exp_t e;
    if (pix_rstn && (exp_q.size() > 0)) begin
      e = exp_q.pop_front();
      checkOutput("sb_seg", {24'h0, seg}, {24'h0, e.seg});
      checkOutput("sb_dig", {29'h0, dig}, {29'h0, e.dig});
      checkOutput("sb_tick", {31'h0, frame_tick}, {31'h0, e.tick});
    end
  end

  task automatic applyStimulus(input logic [11:0] v, input logic [2:0] d, input logic bl, input logic [1:0] br);
    value      = v;
    dp         = d;
    blank_lz   = bl;
    brightness = br;
    load       = 1'b1;
    @(negedge pix_clk);
    load       = 1'b0;
  endtask

  task automatic measureTickGap(output int n);
    n = 0;
    do begin
      @(negedge pix_clk);
      n++;
    end while ((frame_tick !== 1'b1) && (n < 200));
  endtask

  task automatic waitFrameTick();
    int n;
    measureTickGap(n);
    if (frame_tick !== 1'b1) checkOutput("tick_wait_timeout", {31'h0, frame_tick}, 32'h1);
  endtask

  // Entry i holds the pins driven from frame position i (digit i/10, slot cycle i%10).
  task automatic captureFrame();
    for (int i = 0; i < 30; i++) begin
      @(negedge pix_clk);
      cap_seg[i]  = seg;
      cap_dig[i]  = dig;
      cap_tick[i] = frame_tick;
    end
  endtask

  initial begin
    int n;
    int act_cnt;
    int viol;
    int ticks_inside;

    pix_rstn   = 1'b0;
    value      = '0;
    dp         = '0;
    load       = 1'b0;
    blank_lz   = 1'b0;
    brightness = 2'd3;

    repeat (3) @(negedge pix_clk);
    checkOutput("reset_seg", {24'h0, seg}, 32'hFF);
    checkOutput("reset_dig", {29'h0, dig}, 32'h7);
    checkOutput("reset_tick", {31'h0, frame_tick}, 32'h0);

    pix_rstn = 1'b1;
    measureTickGap(n);
    checkOutput("first_tick_latency", n, 30);
    measureTickGap(n);
    checkOutput("tick_period", n, 30);

    $display("[TB] value 123 at full brightness");
    applyStimulus(12'h123, 3'b000, 1'b0, 2'd3);
    waitFrameTick();
    captureFrame();
    checkOutput("d0_guard_seg", {24'h0, cap_seg[0]}, 32'hFF);
    checkOutput("d0_guard_dig", {29'h0, cap_dig[0]}, 32'h7);
    for (int i = 1; i < 10; i++) begin
      checkOutput("d0_on_seg", {24'h0, cap_seg[i]}, 32'hB0);
      checkOutput("d0_on_dig", {29'h0, cap_dig[i]}, 32'h6);
    end
    checkOutput("d1_seg", {24'h0, cap_seg[11]}, 32'hA4);
    checkOutput("d2_seg", {24'h0, cap_seg[21]}, 32'hF9);
    checkOutput("d2_dig", {29'h0, cap_dig[21]}, 32'h3);
    ticks_inside = 0;
    for (int i = 0; i < 29; i++) if (cap_tick[i]) ticks_inside++;
    checkOutput("tick_quiet_in_frame", ticks_inside, 0);
    checkOutput("tick_at_frame_end", {31'h0, cap_tick[29]}, 32'h1);

    $display("[TB] load coinciding with frame wrap");
    repeat (29) @(negedge pix_clk);
    value = 12'h456;
    load  = 1'b1;
    @(negedge pix_clk);
    load  = 1'b0;
    checkOutput("tick_at_load_wrap", {31'h0, frame_tick}, 32'h1);
    captureFrame();
    checkOutput("wrap_load_old_d0", {24'h0, cap_seg[1]}, 32'hB0);
    captureFrame();
    checkOutput("wrap_load_new_d0", {24'h0, cap_seg[1]}, 32'h82);
    checkOutput("wrap_load_new_d1", {24'h0, cap_seg[11]}, 32'h92);

    $display("[TB] leading zero blanking");
    applyStimulus(12'h007, 3'b000, 1'b1, 2'd3);
    waitFrameTick();
    captureFrame();
    checkOutput("lz_d0_seg", {24'h0, cap_seg[1]}, 32'hF8);
    checkOutput("lz_d1_seg", {24'h0, cap_seg[11]}, 32'hFF);
    checkOutput("lz_d1_dig", {29'h0, cap_dig[11]}, 32'h5);
    checkOutput("lz_d2_seg", {24'h0, cap_seg[21]}, 32'hFF);
    checkOutput("lz_d2_dig", {29'h0, cap_dig[21]}, 32'h3);
    blank_lz = 1'b0;
    captureFrame();
    checkOutput("nolz_d1_seg", {24'h0, cap_seg[11]}, 32'hC0);
    checkOutput("nolz_d2_seg", {24'h0, cap_seg[21]}, 32'hC0);

    $display("[TB] decimal point on a blanked digit");
    applyStimulus(12'h007, 3'b010, 1'b1, 2'd3);
    waitFrameTick();
    captureFrame();
    checkOutput("dp_d0_seg", {24'h0, cap_seg[1]}, 32'hF8);
    checkOutput("dp_d1_seg", {24'h0, cap_seg[11]}, 32'h7F);
    checkOutput("dp_d2_seg", {24'h0, cap_seg[21]}, 32'hFF);
    checkOutput("dp_d1_bit7", {31'h0, cap_seg[11][7]}, 32'h0);
    checkOutput("dp_d0_bit7", {31'h0, cap_seg[1][7]}, 32'h1);

    $display("[TB] brightness 1 and 0");
    brightness = 2'd1;
    captureFrame();
    act_cnt = 0;
    viol    = 0;
    for (int i = 0; i < 30; i++) begin
      if (cap_dig[i] != 3'b111) begin
        act_cnt++;
        for (int j = 1; j < 4; j++) begin
          if ((i + j < 30) && (cap_dig[i+j] != 3'b111)) viol++;
        end
      end
    end
    checkOutput("bright1_spacing", viol, 0);
    checkOutput("bright1_count_ok", {31'h0, (act_cnt >= 5) && (act_cnt <= 8)}, 32'h1);
    brightness = 2'd0;
    captureFrame();
    act_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if ((cap_dig[i] != 3'b111) || (cap_seg[i] != 8'hFF)) act_cnt++;
    end
    checkOutput("bright0_dark_cycles", act_cnt, 0);

    $display("[TB] mid-frame load holds until frame tick");
    applyStimulus(12'h000, 3'b000, 1'b0, 2'd3);
    waitFrameTick();
    repeat (5) @(negedge pix_clk);
    applyStimulus(12'hABC, 3'b000, 1'b0, 2'd3);
    n = 0;
    do begin
      @(negedge pix_clk);
      n++;
    end while ((dig !== 3'b011) && (n < 40));
    checkOutput("abc_old_d2", {24'h0, seg}, 32'hC0);
    waitFrameTick();
    captureFrame();
    checkOutput("abc_d0_seg", {24'h0, cap_seg[1]}, 32'hC6);
    checkOutput("abc_d1_seg", {24'h0, cap_seg[11]}, 32'h83);
    checkOutput("abc_d2_seg", {24'h0, cap_seg[21]}, 32'h88);

    $display("[TB] asynchronous reset mid-slot");
    repeat (3) @(negedge pix_clk);
    checkOutput("pre_reset_dig", {29'h0, dig}, 32'h6);
    #2 pix_rstn = 1'b0;
    #1;
    checkOutput("async_reset_seg", {24'h0, seg}, 32'hFF);
    checkOutput("async_reset_dig", {29'h0, dig}, 32'h7);
    checkOutput("async_reset_tick", {31'h0, frame_tick}, 32'h0);
    @(negedge pix_clk);
    pix_rstn = 1'b1;
    @(negedge pix_clk);
    checkOutput("restart_guard_dig", {29'h0, dig}, 32'h7);
    @(negedge pix_clk);
    checkOutput("restart_d0_dig", {29'h0, dig}, 32'h6);
    checkOutput("restart_d0_seg", {24'h0, seg}, 32'hC0);
    measureTickGap(n);
    checkOutput("restart_tick_latency", n + 2, 30);

    repeat (5) @(negedge pix_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter CLK_HZ, default 108_000_000: input clock frequency in Hz.
REQ-002 Parameter NUM_DIGITS, default 3: number of multiplexed digits, range 1..8.
REQ-003 Parameter DIGIT_HZ, default 1000: per-digit slot rate; SLOT_TICKS = CLK_HZ/DIGIT_HZ.
REQ-004 Parameter PWM_BITS, default 4: brightness resolution.
REQ-005 Parameter GUARD_TICKS, default 2: anti-ghosting dead cycles at the start of each slot.
REQ-006 Parameter SEG_ACTIVE_LOW, default 1: segment output polarity.
REQ-007 Parameter DIG_ACTIVE_LOW, default 1: digit-select output polarity.
REQ-008 pix_clk  in  1  single clock; all logic on its rising edge.
REQ-009 pix_rstn  in  1  reset, asynchronous assert, active-low.
REQ-010 value  in  4*NUM_DIGITS  hex nibbles; nibble 0 (bits 3:0) is rightmost digit.
REQ-011 dp  in  NUM_DIGITS  decimal-point enable per digit.
REQ-012 load  in  1  strobe; captures value/dp into shadow register.
REQ-013 blank_lz  in  1  level; enables leading-zero blanking.
REQ-014 brightness  in  PWM_BITS  duty; 0 = off, all-ones = full on.
REQ-015 seg  out  8  bit 7 = dp, bits 6:0 = g..a, polarity per SEG_ACTIVE_LOW.
REQ-016 dig  out  NUM_DIGITS  one-hot digit select, polarity per DIG_ACTIVE_LOW.
REQ-017 frame_tick  out  1  one-cycle pulse at the start of each full scan frame.

Function
REQ-018 slot_cnt SHALL count 0..SLOT_TICKS-1 and wrap; on wrap dig_idx SHALL advance 0,1,..,NUM_DIGITS-1,0.
REQ-019 Elaboration SHALL fail if SLOT_TICKS < GUARD_TICKS + 2**PWM_BITS or NUM_DIGITS outside 1..8.
REQ-020 load high SHALL capture value/dp into shadow on that edge; load every cycle SHALL be legal.
REQ-021 Display register SHALL copy shadow only when dig_idx wraps NUM_DIGITS-1 -> 0 (tear-free); frame_tick SHALL pulse that same cycle.
REQ-022 load coinciding with the frame wrap SHALL land in shadow; display takes the previous shadow, new data one frame later.
REQ-023 pwm_cnt (PWM_BITS wide) SHALL free-run every cycle, wrapping.
REQ-024 Digit active when slot_cnt >= GUARD_TICKS and (brightness all-ones or pwm_cnt < brightness).
REQ-025 When active, exactly one dig bit asserted (index dig_idx); otherwise all dig bits inactive and seg all off.
REQ-026 Decode SHALL cover 0-F (active-high g..a: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,b=7C,C=39,d=5E,E=79,F=71).
REQ-027 blank_lz=1: digit k>0 blanked (seg off, dig still driven) if nibbles k..NUM_DIGITS-1 are all zero; digit 0 never blanked; dp of a blanked digit still shown.
REQ-028 seg/dig SHALL be registered; latency exactly 1 cycle from slot_cnt/dig_idx/pwm_cnt state.
REQ-029 Counter arithmetic SHALL use $clog2-sized widths; no overflow beyond wrap points.

Reset
REQ-030 On pix_rstn low: slot_cnt, dig_idx, pwm_cnt, shadow, display = 0; seg all off; dig all inactive; frame_tick 0.
REQ-031 Reset mid-slot SHALL take effect immediately (async); release resumes at slot 0, digit 0, first frame_tick after one full frame.
REQ-032 Reset deassertion SHALL be consumed synchronously (caller provides synchronised release).

Structure
REQ-033 Package seg7_pkg SHALL hold the hex-to-segment decode function and polarity constants.
REQ-034 Sub-module seg7_tick_gen (slot_cnt/dig_idx/frame_tick) SHALL be instantiated; decode/PWM stay in the top.

Verification (CLK_HZ=1000, DIGIT_HZ=100, NUM_DIGITS=3, PWM_BITS=2, GUARD_TICKS=1, active-low)
REQ-035 Reset then load value=12'h123, brightness=3 -> after next frame wrap, digit0 slot: dig=3'b110, seg=8'hB0 for cycles 1..9 of slot, all off at cycle 0.
REQ-036 value=12'h007, blank_lz=1 -> digit2/digit1 seg=8'hFF, digit0 seg=8'hF8; blank_lz=0 -> digit2/1 seg=8'hC0.
REQ-037 brightness=1 -> digit active 1 cycle in 4 outside guard; brightness=0 -> dig=3'b111 throughout.
REQ-038 load 12'hABC mid-frame -> displayed digits unchanged until frame_tick, then A/b/C (8'h88,8'h83,8'hC6).
REQ-039 frame_tick period = 30 cycles; pix_rstn pulsed low mid-slot -> outputs off in same cycle, restart at digit0.
REQ-040 dp=3'b010 -> digit1 seg bit7 = 0 (on), others bit7 = 1.
